tb_obi_mem_slave: RTL and testbench

Parametrised OBI memory slave for the core testbench, replacing the fixed zero-wait RAM behaviour with configurable grant stalls, response latency, multiple outstanding transactions and an error-response region. One instance serves one OBI port (instruction or data); the testbench wrapper instantiates two. Responses are always returned in order.

---
 rtl/tb_obi_mem_pkg.sv | 29 ++
 rtl/tb_obi_resp_fifo.sv | 89 ++++++++
 rtl/tb_obi_mem_slave.sv | 166 ++++++++++++++++
 tb/tb_tb_obi_mem_slave.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_obi_mem_pkg.sv
// Shared types and helpers for the testbench OBI memory slave.
//   resp_entry_t : one queued response (read data, error flag, latency countdown)
//   gnt_state_t  : grant FSM states
//   err_match    : error-region address decode
package tb_obi_mem_pkg;

  // Widest supported bus; narrower buses use the low bits and leave the rest 0.
  localparam int RESP_DATA_W = 64;
  localparam int CNT_W       = 4;

  typedef enum logic [0:0] {
    G_IDLE = 1'b0,
    G_WAIT = 1'b1
  } gnt_state_t;

  typedef struct packed {
    logic [RESP_DATA_W-1:0] rdata;
    logic                   err;
    logic [CNT_W-1:0]       cnt;
  } resp_entry_t;

  function automatic logic err_match(input logic        en,
                                     input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return en && ((addr & mask) == base);
  endfunction

endpackage

// File: rtl/tb_obi_resp_fifo.sv
// In-order response queue for the OBI memory slave.
// Every stored entry counts its latency down each cycle (saturating at 0);
// only the head may retire, so later entries that are already at 0 follow
// the head on consecutive cycles.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push          : store push_entry at the tail this cycle
//   push_entry    : entry to store
//   pop           : retire the head this cycle
//   head          : current head entry
//   head_ready    : head present and its countdown has reached 0
//   occupancy     : number of stored entries
module tb_obi_resp_fifo
  import tb_obi_mem_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push,
  input  resp_entry_t       push_entry,
  input  logic              pop,
  output resp_entry_t       head,
  output logic              head_ready,
  output logic [OCC_W-1:0]  occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_entry_t            entries   [DEPTH];
  resp_entry_t            entries_n [DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [OCC_W-1:0]       count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return PTR_W'(0);
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign head       = entries[rd_ptr];
  assign head_ready = (count != OCC_W'(0)) && (head.cnt == CNT_W'(0));
  assign occupancy  = count;

  // Next-state of the storage: new entry at the tail, countdown everywhere else.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_n[i] = entries[i];
      if (push && (wr_ptr == PTR_W'(i))) begin
        entries_n[i] = push_entry;
      end else if (entries[i].cnt != CNT_W'(0)) begin
        entries_n[i].cnt = entries[i].cnt - CNT_W'(1);
      end else begin
        entries_n[i].cnt = CNT_W'(0);
      end
    end
  end

  // Storage, pointers and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      rd_ptr <= PTR_W'(0);
      wr_ptr <= PTR_W'(0);
      count  <= OCC_W'(0);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= entries_n[i];
      end
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tb_obi_mem_slave.sv
// Parametrised OBI memory slave used by the core testbench.
// Adds configurable grant stalls, per-transaction response latency, several
// outstanding transactions (responses kept in order) and an error region.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   req_i/gnt_o     : OBI address-phase handshake (gnt_o is combinational)
//   addr_i, we_i, be_i, wdata_i : request attributes
//   rvalid_o, rdata_o, err_o    : response phase; rdata_o/err_o are 0 when idle
//   gnt_stall_i     : cycles req_i must be held before a grant
//   rvalid_lat_i    : extra response latency, captured at grant
module tb_obi_mem_slave
  import tb_obi_mem_pkg::*;
#(
  parameter int          MEM_ADDR_WIDTH  = 20,
  parameter int          DATA_WIDTH      = 32,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          ERR_EN          = 0,
  parameter logic [31:0] ERR_BASE        = 32'hFFFF_0000,
  parameter logic [31:0] ERR_MASK        = 32'hFFFF_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [31:0]             addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  input  logic [3:0]              gnt_stall_i,
  input  logic [3:0]              rvalid_lat_i
);

  localparam int BE_W     = DATA_WIDTH / 8;
  localparam int WORD_OFF = $clog2(BE_W);
  localparam int WORD_AW  = MEM_ADDR_WIDTH - WORD_OFF;
  localparam int DEPTH    = 1 << WORD_AW;
  localparam int OCC_W    = $clog2(MAX_OUTSTANDING + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [WORD_AW-1:0]    word_idx;
  logic                  addr_err;

  gnt_state_t            state;
  gnt_state_t            state_n;
  logic [3:0]            stall_cnt;
  logic [3:0]            stall_cnt_n;
  logic                  gnt;
  logic                  space;

  resp_entry_t           push_entry;
  resp_entry_t           head;
  logic                  head_ready;
  logic [OCC_W-1:0]      occupancy;

  // Upper address bits alias onto the same storage.
  assign word_idx = addr_i[MEM_ADDR_WIDTH-1:WORD_OFF];
  assign addr_err = err_match(ERR_EN != 0, addr_i, ERR_BASE, ERR_MASK);

  // A full queue can still accept a push when its head retires this cycle.
  assign space = (occupancy < OCC_W'(MAX_OUTSTANDING)) ||
                 ((occupancy == OCC_W'(MAX_OUTSTANDING)) && head_ready);

  assign gnt_o = gnt;

  // Grant decision and stall counting; depends only on req_i, stall config and queue state.
  always_comb begin
    gnt         = 1'b0;
    state_n     = state;
    stall_cnt_n = stall_cnt;
    case (state)
      G_IDLE: begin
        if (req_i) begin
          if ((gnt_stall_i == 4'd0) && space) begin
            gnt = 1'b1;
          end else begin
            state_n     = G_WAIT;
            stall_cnt_n = 4'd1;
          end
        end else begin
          stall_cnt_n = 4'd0;
        end
      end
      G_WAIT: begin
        if (!req_i) begin
          // Request withdrawn before grant: abandon it.
          state_n     = G_IDLE;
          stall_cnt_n = 4'd0;
        end else if ((stall_cnt >= gnt_stall_i) && space) begin
          gnt         = 1'b1;
          state_n     = G_IDLE;
          stall_cnt_n = 4'd0;
        end else if (stall_cnt != 4'hF) begin
          stall_cnt_n = stall_cnt + 4'd1;
        end else begin
          stall_cnt_n = stall_cnt;
        end
      end
      default: begin
        state_n     = G_IDLE;
        stall_cnt_n = 4'd0;
      end
    endcase
  end

  // Grant FSM state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= G_IDLE;
      stall_cnt <= 4'd0;
    end else begin
      state     <= state_n;
      stall_cnt <= stall_cnt_n;
    end
  end

  // Response captured at grant: read data sampled before this cycle's write lands.
  always_comb begin
    push_entry     = '0;
    push_entry.cnt = rvalid_lat_i;
    if (addr_err) begin
      push_entry.err = 1'b1;
    end else if (!we_i) begin
      push_entry.rdata[DATA_WIDTH-1:0] = mem[word_idx];
    end else begin
      push_entry.err = 1'b0;
    end
  end

  // Byte-enabled write commit at grant; storage deliberately has no reset.
  always_ff @(posedge clk_i) begin
    if (gnt && we_i && !addr_err) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) begin
          mem[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  tb_obi_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .OCC_W (OCC_W)
  ) u_resp_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push       (gnt),
    .push_entry (push_entry),
    .pop        (head_ready),
    .head       (head),
    .head_ready (head_ready),
    .occupancy  (occupancy)
  );

  // Response outputs come straight from queue flops, forced to 0 while idle.
  assign rvalid_o = head_ready;
  assign rdata_o  = head_ready ? head.rdata[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
  assign err_o    = head_ready ? head.err : 1'b0;

  if (DATA_WIDTH < RESP_DATA_W) begin : g_narrow
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^head.rdata[RESP_DATA_W-1:DATA_WIDTH];
  end

endmodule

// File: tb/tb_tb_obi_mem_slave.sv
// Self-checking bench for tb_obi_mem_slave (32-bit bus, 2 outstanding, error region on).
// A scoreboard queue holds the expected response data, error flag and exact
// response cycle for each granted request; a monitor pops and compares.
module tb_tb_obi_mem_slave;

  localparam logic [31:0] ERR_BASE_C = 32'hFFFF_0000;
  localparam logic [31:0] ERR_MASK_C = 32'hFFFF_0000;

  logic        clk;
  logic        rst_ni;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [3:0]  gnt_stall_i;
  logic [3:0]  rvalid_lat_i;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model_mem [int];
  int          cyc;
  int          last_resp;
  int          vectors;
  int          miscompares;

  tb_obi_mem_slave #(
    .MEM_ADDR_WIDTH  (20),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (2),
    .ERR_EN          (1),
    .ERR_BASE        (ERR_BASE_C),
    .ERR_MASK        (ERR_MASK_C)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .addr_i       (addr_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .wdata_i      (wdata_i),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .gnt_stall_i  (gnt_stall_i),
    .rvalid_lat_i (rvalid_lat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every response must match the head of the expectation queue.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_ni === 1'b1) begin
      vectors++;
      if (rvalid_o === 1'b1) begin
        if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_unexpected cyc=%0d rdata=%h err=%b, no response expected", cyc, rdata_o, err_o);
        end else begin
          e = sbq.pop_front();
          if (rdata_o !== e.data || err_o !== e.err || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL rsp_check got rdata=%h err=%b cyc=%0d, exp rdata=%h err=%b cyc=%0d",
                     rdata_o, err_o, cyc, e.data, e.err, e.cyc);
          end
        end
      end else if (rvalid_o !== 1'b0 || rdata_o !== 32'h0 || err_o !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_outputs got rvalid=%b rdata=%h err=%b, exp 0/0/0", rvalid_o, rdata_o, err_o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // Issue one request (entered at posedge+1), wait for grant, record expectation.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input logic [3:0] stall,
                        input logic [3:0] lat, output int waits);
    exp_t        e;
    int          w;
    int          widx;
    int          rc;
    logic        is_err;
    logic [31:0] word;
    req_i        = 1'b1;
    we_i         = we;
    addr_i       = addr;
    be_i         = be;
    wdata_i      = wdata;
    gnt_stall_i  = stall;
    rvalid_lat_i = lat;
    #1;
    w = 0;
    while (gnt_o !== 1'b1 && w < 40) begin
      @(posedge clk);
      #2;
      w++;
    end
    waits = w;
    if (gnt_o !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL grant_timeout addr=%h waited %0d cycles, exp a grant", addr, w);
      req_i = 1'b0;
      @(posedge clk);
      #1;
    end else begin
      is_err = ((addr & ERR_MASK_C) == ERR_BASE_C);
      widx   = int'(addr[19:2]);
      e.err  = is_err;
      e.data = 32'h0;
      if (!is_err) begin
        word = model_mem.exists(widx) ? model_mem[widx] : 32'h0;
        if (we) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
          end
          model_mem[widx] = word;
        end else begin
          e.data = word;
        end
      end
      rc = cyc + 1 + int'(lat);
      if (last_resp + 1 > rc) rc = last_resp + 1;
      e.cyc     = rc;
      last_resp = rc;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      req_i = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain got %0d pending, exp 0", name, sbq.size());
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #3;
    vectors++;
    if (gnt_o !== 1'b0 || rvalid_o !== 1'b0 || rdata_o !== 32'h0 || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got gnt=%b rvalid=%b rdata=%h err=%b, exp all 0",
               gnt_o, rvalid_o, rdata_o, err_o);
    end
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int w[8];
    do_txn(1'b1, 32'h100, 4'hF, 32'h1122_3344, 4'd0, 4'd0, w[0]);
    do_txn(1'b1, 32'h104, 4'hF, 32'h5566_7788, 4'd0, 4'd0, w[1]);
    do_txn(1'b1, 32'h100, 4'h3, 32'hAAAA_BBBB, 4'd0, 4'd0, w[2]);
    do_txn(1'b1, 32'h104, 4'h3, 32'hCCCC_DDDD, 4'd0, 4'd0, w[3]);
    do_txn(1'b0, 32'h100, 4'hF, 32'h0,         4'd0, 4'd0, w[4]);
    do_txn(1'b0, 32'h104, 4'hF, 32'h0,         4'd0, 4'd0, w[5]);
    do_txn(1'b1, 32'h108, 4'hF, 32'h0BAD_CAFE, 4'd0, 4'd0, w[6]);
    do_txn(1'b0, 32'h108, 4'hF, 32'h0,         4'd0, 4'd0, w[7]);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (w[i] !== 0) begin
        miscompares++;
        $display("FAIL basic_gnt txn %0d waited %0d cycles, exp 0", i, w[i]);
      end
    end
    wait_drain("basic");
  endtask

  task automatic test_stall();
    int w3;
    int w1;
    do_txn(1'b1, 32'h10C, 4'hF, 32'h0F0F_0F0F, 4'd3, 4'd0, w3);
    do_txn(1'b0, 32'h10C, 4'hF, 32'h0,         4'd1, 4'd0, w1);
    vectors++;
    if (w3 !== 3) begin
      miscompares++;
      $display("FAIL stall3_gnt waited %0d cycles, exp 3", w3);
    end
    vectors++;
    if (w1 !== 1) begin
      miscompares++;
      $display("FAIL stall1_gnt waited %0d cycles, exp 1", w1);
    end
    wait_drain("stall");
  endtask

  task automatic test_outstanding();
    int w[4];
    int exp_w[4];
    exp_w = '{0, 0, 4, 0};
    do_txn(1'b0, 32'h100, 4'hF, 32'h0, 4'd0, 4'd5, w[0]);
    do_txn(1'b0, 32'h104, 4'hF, 32'h0, 4'd0, 4'd5, w[1]);
    do_txn(1'b0, 32'h108, 4'hF, 32'h0, 4'd0, 4'd5, w[2]);
    do_txn(1'b0, 32'h10C, 4'hF, 32'h0, 4'd0, 4'd5, w[3]);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (w[i] !== exp_w[i]) begin
        miscompares++;
        $display("FAIL outstanding_gnt txn %0d waited %0d cycles, exp %0d", i, w[i], exp_w[i]);
      end
    end
    wait_drain("outstanding");
  endtask

  task automatic test_latency_order();
    int wa;
    int wb;
    do_txn(1'b0, 32'h100, 4'hF, 32'h0, 4'd0, 4'd4, wa);
    do_txn(1'b0, 32'h108, 4'hF, 32'h0, 4'd0, 4'd0, wb);
    vectors++;
    if (wa !== 0 || wb !== 0) begin
      miscompares++;
      $display("FAIL order_gnt waited %0d/%0d cycles, exp 0/0", wa, wb);
    end
    wait_drain("order");
  endtask

  task automatic test_error();
    int w;
    do_txn(1'b1, 32'h000F_0010, 4'hF, 32'h0BAD_F00D, 4'd0, 4'd0, w);
    do_txn(1'b1, 32'hFFFF_0010, 4'hF, 32'h0000_DEAD, 4'd0, 4'd0, w);
    do_txn(1'b0, 32'hFFFF_0010, 4'hF, 32'h0,         4'd0, 4'd0, w);
    do_txn(1'b0, 32'h000F_0010, 4'hF, 32'h0,         4'd0, 4'd0, w);
    wait_drain("error");
  endtask

  task automatic test_reset_pending();
    int w;
    int seen;
    do_txn(1'b0, 32'h100, 4'hF, 32'h0, 4'd0, 4'd8, w);
    do_txn(1'b0, 32'h104, 4'hF, 32'h0, 4'd0, 4'd8, w);
    rst_ni = 1'b0;
    #1;
    vectors++;
    if (gnt_o !== 1'b0 || rvalid_o !== 1'b0 || rdata_o !== 32'h0 || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs got gnt=%b rvalid=%b rdata=%h err=%b, exp all 0",
               gnt_o, rvalid_o, rdata_o, err_o);
    end
    sbq.delete();
    last_resp = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (rvalid_o !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset_discard got %0d rvalid cycles after release, exp 0", seen);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni       = 1'b0;
    req_i        = 1'b0;
    we_i         = 1'b0;
    addr_i       = 32'h0;
    be_i         = 4'h0;
    wdata_i      = 32'h0;
    gnt_stall_i  = 4'd0;
    rvalid_lat_i = 4'd0;
    cyc          = 0;
    last_resp    = 0;
    vectors      = 0;
    miscompares  = 0;
    test_reset();
    test_basic();
    test_stall();
    test_outstanding();
    test_latency_order();
    test_error();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
